tiger_irq_ctrl: RTL and testbench
=================================

Name: tiger_irq_ctrl

Overview:
Interrupt controller that sequences external interrupt lines into the decode stage's single irq/irqNumber pair. Synchronises, edge/level-qualifies, masks and prioritises NUM_IRQ sources. Holds one request stable until decode accepts it, then enforces a hold-off before presenting the next. Sits between peripherals and the decode stage; acceptance is inferred from decode's exception, stall and clear signals.

Parameters:
NUM_IRQ, 8, number of interrupt sources (1..64; index = irqNumber)
SYNC_STAGES, 2, synchroniser flops per line (>=2)
HOLDOFF, 2, cycles irq is suppressed after acceptance (>=1)

Ports:
clk  in  1  pipeline clock
reset  in  1  asynchronous, active-low reset
irqLines  in  NUM_IRQ  raw asynchronous interrupt lines
edgeSel  in  NUM_IRQ  per line: 1 = rising-edge source, 0 = level-high source
maskWrEn  in  1  write strobe for mask register
maskWrData  in  NUM_IRQ  new mask (1 = enabled)
pendClrEn  in  1  write-1-to-clear strobe for edge pending bits
pendClrData  in  NUM_IRQ  bits to clear
stall  in  1  decode stall (same signal driving decode)
clear  in  1  decode clear (same signal driving decode)
exceptionDe  in  1  decode's exception output
irq  out  1  interrupt request to decode (registered)
irqNumber  out  6  index of presented source (registered, zero-extended)
pending  out  NUM_IRQ  raw pending register, for software read
mask  out  NUM_IRQ  current mask register

Behaviour:
- Reset (reset low, async): all sync flops, pending, mask, edge-history = 0; state IDLE; irq = 0; irqNumber = 0.
- Sync: each line through SYNC_STAGES flops; s = final stage; prev = s delayed one cycle.
- Pending per line, each cycle: edge source sets on s & !prev; level source pending = s (follows line). Edge bit cleared by pendClrEn&pendClrData or by acceptance of that index; set wins over clear in same cycle.
- Eligible = pending & mask. Winner = lowest set index (fixed priority).
- accept = irq & exceptionDe & !stall & !clear.
- FSM:
  IDLE: eligible != 0 -> PRESENT; irqNumber <= winner, irq <= 1.
  PRESENT: irqNumber held stable (no re-arbitration). accept -> HOLD, irq <= 0, counter <= HOLDOFF-1. Else presented bit no longer eligible (masked, level dropped, or SW-cleared) -> IDLE, irq <= 0. accept has priority over withdrawal in same cycle.
  HOLD: irq = 0; counter decrements; at 0 -> IDLE.
- Latency: edge line rising at cycle 0 -> irq high after SYNC_STAGES+2 rising edges (4 at default). From IDLE with eligible already set: 1 cycle.
- stall or clear while PRESENT: stay PRESENT, no acceptance.
- Mask write takes effect next cycle; masking the presented line withdraws it.
- Level source accepted: not cleared here; if still asserted after HOLD it re-presents (software must clear device).
- Acceptance clears the edge bit of irqNumber only; a new edge on that line in the acceptance cycle is kept (set wins).
- exceptionDe high with irq low (break/syscall): ignored.
- reset low mid-PRESENT/HOLD: immediate return to reset values.

Decomposition:
- Shared defines: IRQ_NUM_WIDTH (6), FSM state encodings (IDLE/PRESENT/HOLD) in tiger_defines.v.
- One sub-module: tiger_irq_sync (per-line SYNC_STAGES synchroniser plus prev register), instantiated in a generate loop. Priority encoder and FSM stay in the top.

Test Plan:
- Reset: hold reset low with irqLines=8'hFF -> irq=0, irqNumber=0, pending=0, mask=0; release, mask still 0 -> irq never asserts.
- Edge latency: mask=8'hFF, edgeSel=8'hFF, pulse line 3 one cycle at cycle 0 -> irq=1, irqNumber=3 at edge 4; exceptionDe=1, stall=0, clear=0 -> next cycle irq=0, pending[3]=0, irq stays 0 for 2 cycles.
- Priority/stability: lines 5 then 2 rise 1 cycle later -> irqNumber=5 held until accept; after HOLDOFF, irqNumber=2 presented.
- Stall/clear: PRESENT with exceptionDe=1, stall=1 for 3 cycles then clear=1 1 cycle -> irq stays 1, pending unchanged; stall=clear=0 -> accepted.
- Withdrawal: level line 0 (edgeSel[0]=0) high, presented; drop line before accept -> irq falls SYNC_STAGES+1 cycles later, FSM IDLE; mask write 0 during PRESENT of line 4 -> irq=0 next cycle.
- Same-cycle set/clear: accept line 1 in the cycle its synchronised edge reappears -> pending[1] remains 1, re-presented after HOLD.

Source files
------------

// File: rtl/tiger_irq_ctrl_pkg.sv
// Shared types and constants for the interrupt controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package tiger_irq_ctrl_pkg;

  // irqNumber is always presented zero-extended to this width (max 64 sources)
  localparam int IRQ_NUM_WIDTH = 6;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESENT = 2'd1,
    ST_HOLD    = 2'd2
  } irq_state_e;

endpackage

// File: rtl/tiger_irq_ctrl_if.sv
// Bundle of peripheral-side and decode-side signals of the interrupt controller.
// Latency: n/a (wiring only).
// Backpressure: decode stalls/clears hold the presented request; see controller.
interface tiger_irq_ctrl_if #(
  parameter int NUM_IRQ = 8
);
  import tiger_irq_ctrl_pkg::*;

  logic [NUM_IRQ-1:0]       irqLines;
  logic [NUM_IRQ-1:0]       edgeSel;
  logic                     maskWrEn;
  logic [NUM_IRQ-1:0]       maskWrData;
  logic                     pendClrEn;
  logic [NUM_IRQ-1:0]       pendClrData;
  logic                     stall;
  logic                     clear;
  logic                     exceptionDe;
  logic                     irq;
  logic [IRQ_NUM_WIDTH-1:0] irqNumber;
  logic [NUM_IRQ-1:0]       pending;
  logic [NUM_IRQ-1:0]       mask;

  // Controller side
  modport slave (
    input  irqLines, edgeSel, maskWrEn, maskWrData, pendClrEn, pendClrData,
    input  stall, clear, exceptionDe,
    output irq, irqNumber, pending, mask
  );

  // Environment side (peripherals, software, decode)
  modport master (
    output irqLines, edgeSel, maskWrEn, maskWrData, pendClrEn, pendClrData,
    output stall, clear, exceptionDe,
    input  irq, irqNumber, pending, mask
  );

endinterface

// File: rtl/tiger_irq_sync.sv
// Per-line synchroniser chain plus a one-cycle-delayed copy for edge detection.
// Latency: SYNC_STAGES cycles to s_o, one more to prev_o.
// Backpressure: none; free-running every cycle.
module tiger_irq_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic line_i,
  output logic s_o,
  output logic prev_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Shift the raw line through the chain; prev trails the final stage by one cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], line_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign s_o    = sync_q[SYNC_STAGES-1];
  assign prev_o = prev_q;

endmodule

// File: rtl/tiger_irq_ctrl.sv
// Synchronise, qualify, mask and prioritise interrupt lines into one irq/irqNumber for decode.
// Latency: edge line to irq = SYNC_STAGES+2 cycles; from IDLE with a source already eligible, 1 cycle.
// Backpressure: request held stable while decode stalls/clears; HOLDOFF quiet cycles after acceptance.
module tiger_irq_ctrl
  import tiger_irq_ctrl_pkg::*;
#(
  parameter int NUM_IRQ     = 8,
  parameter int SYNC_STAGES = 2,
  parameter int HOLDOFF     = 2
) (
  input logic              clk,
  input logic              reset,
  tiger_irq_ctrl_if.slave  bus
);

  localparam int CNT_W = $clog2(HOLDOFF + 1);

  logic [NUM_IRQ-1:0]       s, prev;
  logic [NUM_IRQ-1:0]       pend_edge_q, pend_edge_d;
  logic [NUM_IRQ-1:0]       mask_q, mask_d;
  logic [NUM_IRQ-1:0]       pending, elig;
  logic [IRQ_NUM_WIDTH-1:0] winner, irq_num_q;
  logic                     any_elig, pres_elig, accept, irq_q;
  irq_state_e               state_q;
  logic [CNT_W-1:0]         cnt_q;

  genvar g;
  generate
    for (g = 0; g < NUM_IRQ; g++) begin : g_sync
      tiger_irq_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk    (clk),
        .reset  (reset),
        .line_i (bus.irqLines[g]),
        .s_o    (s[g]),
        .prev_o (prev[g])
      );
    end
  endgenerate

  // Level bits come straight from the last synchroniser flop; edge bits are latched
  assign pending = (pend_edge_q & bus.edgeSel) | (s & ~bus.edgeSel);
  assign elig    = pending & mask_q;
  assign accept  = irq_q & bus.exceptionDe & ~bus.stall & ~bus.clear;
  assign mask_d  = bus.maskWrEn ? bus.maskWrData : mask_q;

  // Fixed priority (lowest index wins) and eligibility of the currently presented source
  always_comb begin
    winner    = '0;
    pres_elig = 1'b0;
    any_elig  = |elig;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (elig[i]) winner = IRQ_NUM_WIDTH'(i);
    end
    for (int i = 0; i < NUM_IRQ; i++) begin
      pres_elig = pres_elig | (elig[i] & (irq_num_q == IRQ_NUM_WIDTH'(i)));
    end
  end

  // Edge pending: a new rising edge wins over software clear or acceptance in the same cycle
  always_comb begin
    pend_edge_d = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      pend_edge_d[i] = bus.edgeSel[i] &
                       ((s[i] & ~prev[i]) |
                        (pend_edge_q[i] &
                         ~((bus.pendClrEn & bus.pendClrData[i]) |
                           (accept & (irq_num_q == IRQ_NUM_WIDTH'(i))))));
    end
  end

  // Software-visible registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_edge_q <= '0;
      mask_q      <= '0;
    end else begin
      pend_edge_q <= pend_edge_d;
      mask_q      <= mask_d;
    end
  end

  // Presentation FSM: irqNumber frozen while presenting, quiet period after acceptance
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      irq_q     <= 1'b0;
      irq_num_q <= '0;
      cnt_q     <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (any_elig) begin
            state_q   <= ST_PRESENT;
            irq_q     <= 1'b1;
            irq_num_q <= winner;
          end
        end
        ST_PRESENT: begin
          if (accept) begin
            state_q <= ST_HOLD;
            irq_q   <= 1'b0;
            cnt_q   <= CNT_W'(HOLDOFF - 1);
          end else if (!pres_elig) begin
            state_q <= ST_IDLE;
            irq_q   <= 1'b0;
          end
        end
        ST_HOLD: begin
          irq_q <= 1'b0;
          if (cnt_q == '0) state_q <= ST_IDLE;
          else             cnt_q   <= cnt_q - CNT_W'(1);
        end
        default: begin
          state_q <= ST_IDLE;
          irq_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.irq       = irq_q;
  assign bus.irqNumber = irq_num_q;
  assign bus.pending   = pending;
  assign bus.mask      = mask_q;

endmodule

// File: tb/tb_tiger_irq_ctrl.sv
// Directed bench for the interrupt controller at default parameters.
// Latency: inputs driven 1 time unit after a rising edge, outputs sampled at the same point.
// Backpressure: decode stall/clear/exception driven directly by the scenarios.
module tb_tiger_irq_ctrl;

  logic clk;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  tiger_irq_ctrl_if #(.NUM_IRQ(8)) bus ();

  tiger_irq_ctrl #(.NUM_IRQ(8), .SYNC_STAGES(2), .HOLDOFF(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.irqLines = 8'hFF; bus.edgeSel = 8'hFF;
    bus.maskWrEn = 1'b0; bus.maskWrData = 8'h00;
    bus.pendClrEn = 1'b0; bus.pendClrData = 8'h00;
    bus.stall = 1'b0; bus.clear = 1'b0; bus.exceptionDe = 1'b0;
    repeat (3) step();
    n_checks++; if (bus.irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq got %0h want 0", bus.irq); end
    n_checks++; if (bus.irqNumber !== 6'd0) begin n_fail++; $display("FAIL reset_num got %0d want 0", bus.irqNumber); end
    n_checks++; if (bus.pending !== 8'h00) begin n_fail++; $display("FAIL reset_pending got %0h want 00", bus.pending); end
    n_checks++; if (bus.mask !== 8'h00) begin n_fail++; $display("FAIL reset_mask got %0h want 00", bus.mask); end
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      n_checks++; if (bus.irq !== 1'b0) begin n_fail++; $display("FAIL masked_irq cyc %0d got %0h want 0", i, bus.irq); end
    end
    n_checks++; if (bus.pending !== 8'hFF) begin n_fail++; $display("FAIL post_reset_pending got %0h want ff", bus.pending); end
    bus.irqLines = 8'h00;
    repeat (3) step();
    bus.pendClrEn = 1'b1; bus.pendClrData = 8'hFF;
    step();
    bus.pendClrEn = 1'b0; bus.pendClrData = 8'h00;
    n_checks++; if (bus.pending !== 8'h00) begin n_fail++; $display("FAIL sw_clear got %0h want 00", bus.pending); end
  endtask

  task automatic test_edge_latency();
    bus.maskWrEn = 1'b1; bus.maskWrData = 8'hFF;
    step();
    bus.maskWrEn = 1'b0;
    n_checks++; if (bus.mask !== 8'hFF) begin n_fail++; $display("FAIL mask_write got %0h want ff", bus.mask); end
    bus.irqLines[3] = 1'b1;
    step();
    bus.irqLines[3] = 1'b0;
    step(); step();
    n_checks++; if (bus.irq !== 1'b0) begin n_fail++; $display("FAIL lat_early got %0h want 0", bus.irq); end
    n_checks++; if (bus.pending !== 8'h08) begin n_fail++; $display("FAIL lat_pending got %0h want 08", bus.pending); end
    step();
    n_checks++; if (bus.irq !== 1'b1) begin n_fail++; $display("FAIL lat_irq got %0h want 1", bus.irq); end
    n_checks++; if (bus.irqNumber !== 6'd3) begin n_fail++; $display("FAIL lat_num got %0d want 3", bus.irqNumber); end
    bus.exceptionDe = 1'b1;
    step();
    bus.exceptionDe = 1'b0;
    n_checks++; if (bus.irq !== 1'b0) begin n_fail++; $display("FAIL acc_irq got %0h want 0", bus.irq); end
    n_checks++; if (bus.pending !== 8'h00) begin n_fail++; $display("FAIL acc_pending got %0h want 00", bus.pending); end
    for (int i = 0; i < 2; i++) begin
      step();
      n_checks++; if (bus.irq !== 1'b0) begin n_fail++; $display("FAIL holdoff cyc %0d got %0h want 0", i, bus.irq); end
    end
  endtask

  task automatic test_priority();
    bus.irqLines[5] = 1'b1;
    step();
    bus.irqLines[2] = 1'b1;
    step(); step(); step();
    n_checks++; if (bus.irq !== 1'b1 || bus.irqNumber !== 6'd5) begin n_fail++; $display("FAIL prio_first got irq=%0h num=%0d want 1/5", bus.irq, bus.irqNumber); end
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++; if (bus.irq !== 1'b1 || bus.irqNumber !== 6'd5 || bus.pending !== 8'h24) begin
        n_fail++; $display("FAIL prio_stable cyc %0d got irq=%0h num=%0d pend=%0h want 1/5/24", i, bus.irq, bus.irqNumber, bus.pending);
      end
    end
    bus.exceptionDe = 1'b1;
    step();
    bus.exceptionDe = 1'b0;
    n_checks++; if (bus.irq !== 1'b0 || bus.pending !== 8'h04) begin n_fail++; $display("FAIL prio_accept got irq=%0h pend=%0h want 0/04", bus.irq, bus.pending); end
    step(); step();
    n_checks++; if (bus.irq !== 1'b0) begin n_fail++; $display("FAIL prio_hold got %0h want 0", bus.irq); end
    step();
    n_checks++; if (bus.irq !== 1'b1 || bus.irqNumber !== 6'd2) begin n_fail++; $display("FAIL prio_second got irq=%0h num=%0d want 1/2", bus.irq, bus.irqNumber); end
    bus.exceptionDe = 1'b1;
    step();
    bus.exceptionDe = 1'b0;
    bus.irqLines = 8'h00;
    n_checks++; if (bus.pending !== 8'h00) begin n_fail++; $display("FAIL prio_clear got %0h want 00", bus.pending); end
    repeat (3) step();
  endtask

  task automatic test_stall_clear();
    bus.irqLines[6] = 1'b1;
    step();
    bus.irqLines[6] = 1'b0;
    step(); step(); step();
    n_checks++; if (bus.irq !== 1'b1 || bus.irqNumber !== 6'd6) begin n_fail++; $display("FAIL stall_present got irq=%0h num=%0d want 1/6", bus.irq, bus.irqNumber); end
    bus.exceptionDe = 1'b1; bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++; if (bus.irq !== 1'b1 || bus.pending !== 8'h40) begin n_fail++; $display("FAIL stall_hold cyc %0d got irq=%0h pend=%0h want 1/40", i, bus.irq, bus.pending); end
    end
    bus.stall = 1'b0; bus.clear = 1'b1;
    step();
    n_checks++; if (bus.irq !== 1'b1 || bus.pending !== 8'h40) begin n_fail++; $display("FAIL clear_hold got irq=%0h pend=%0h want 1/40", bus.irq, bus.pending); end
    bus.clear = 1'b0;
    step();
    bus.exceptionDe = 1'b0;
    n_checks++; if (bus.irq !== 1'b0 || bus.pending !== 8'h00) begin n_fail++; $display("FAIL stall_accept got irq=%0h pend=%0h want 0/00", bus.irq, bus.pending); end
    repeat (2) step();
  endtask

  task automatic test_withdrawal();
    bus.edgeSel = 8'hFE;
    bus.irqLines[0] = 1'b1;
    step(); step(); step();
    n_checks++; if (bus.irq !== 1'b1 || bus.irqNumber !== 6'd0) begin n_fail++; $display("FAIL level_present got irq=%0h num=%0d want 1/0", bus.irq, bus.irqNumber); end
    bus.irqLines[0] = 1'b0;
    step(); step();
    n_checks++; if (bus.irq !== 1'b1 || bus.pending !== 8'h00) begin n_fail++; $display("FAIL level_drop_early got irq=%0h pend=%0h want 1/00", bus.irq, bus.pending); end
    step();
    n_checks++; if (bus.irq !== 1'b0) begin n_fail++; $display("FAIL level_withdraw got %0h want 0", bus.irq); end
    bus.edgeSel = 8'hFF;
    step();
    bus.irqLines[4] = 1'b1;
    step();
    bus.irqLines[4] = 1'b0;
    step(); step(); step();
    n_checks++; if (bus.irq !== 1'b1 || bus.irqNumber !== 6'd4) begin n_fail++; $display("FAIL mask_present got irq=%0h num=%0d want 1/4", bus.irq, bus.irqNumber); end
    bus.maskWrEn = 1'b1; bus.maskWrData = 8'hEF;
    step();
    bus.maskWrEn = 1'b0;
    n_checks++; if (bus.mask !== 8'hEF || bus.irq !== 1'b1) begin n_fail++; $display("FAIL mask_update got mask=%0h irq=%0h want ef/1", bus.mask, bus.irq); end
    step();
    n_checks++; if (bus.irq !== 1'b0 || bus.pending !== 8'h10) begin n_fail++; $display("FAIL mask_withdraw got irq=%0h pend=%0h want 0/10", bus.irq, bus.pending); end
    bus.maskWrEn = 1'b1; bus.maskWrData = 8'hFF;
    step();
    bus.maskWrEn = 1'b0;
    step();
    n_checks++; if (bus.irq !== 1'b1 || bus.irqNumber !== 6'd4) begin n_fail++; $display("FAIL unmask_present got irq=%0h num=%0d want 1/4", bus.irq, bus.irqNumber); end
    bus.exceptionDe = 1'b1;
    step();
    bus.exceptionDe = 1'b0;
    repeat (2) step();
  endtask

  task automatic test_back_to_back();
    bus.irqLines[1] = 1'b1;
    step();
    bus.irqLines[1] = 1'b0;
    step(); step(); step();
    n_checks++; if (bus.irq !== 1'b1 || bus.irqNumber !== 6'd1) begin n_fail++; $display("FAIL b2b_present got irq=%0h num=%0d want 1/1", bus.irq, bus.irqNumber); end
    bus.irqLines[1] = 1'b1;
    step(); step();
    bus.exceptionDe = 1'b1;
    step();
    bus.exceptionDe = 1'b0;
    n_checks++; if (bus.irq !== 1'b0 || bus.pending !== 8'h02) begin n_fail++; $display("FAIL b2b_setwins got irq=%0h pend=%0h want 0/02", bus.irq, bus.pending); end
    step(); step();
    n_checks++; if (bus.irq !== 1'b0) begin n_fail++; $display("FAIL b2b_hold got %0h want 0", bus.irq); end
    step();
    n_checks++; if (bus.irq !== 1'b1 || bus.irqNumber !== 6'd1) begin n_fail++; $display("FAIL b2b_represent got irq=%0h num=%0d want 1/1", bus.irq, bus.irqNumber); end
    bus.exceptionDe = 1'b1;
    step();
    bus.exceptionDe = 1'b0;
    bus.irqLines = 8'h00;
    n_checks++; if (bus.pending !== 8'h00) begin n_fail++; $display("FAIL b2b_clear got %0h want 00", bus.pending); end
    repeat (3) step();
  endtask

  task automatic test_spurious_exception();
    bus.exceptionDe = 1'b1;
    bus.irqLines[7] = 1'b1;
    step();
    bus.irqLines[7] = 1'b0;
    step(); step();
    n_checks++; if (bus.irq !== 1'b0 || bus.pending !== 8'h80) begin n_fail++; $display("FAIL spur_ignored got irq=%0h pend=%0h want 0/80", bus.irq, bus.pending); end
    step();
    n_checks++; if (bus.irq !== 1'b1 || bus.irqNumber !== 6'd7 || bus.pending !== 8'h80) begin
      n_fail++; $display("FAIL spur_present got irq=%0h num=%0d pend=%0h want 1/7/80", bus.irq, bus.irqNumber, bus.pending);
    end
    step();
    bus.exceptionDe = 1'b0;
    n_checks++; if (bus.irq !== 1'b0 || bus.pending !== 8'h00) begin n_fail++; $display("FAIL spur_accept got irq=%0h pend=%0h want 0/00", bus.irq, bus.pending); end
    repeat (2) step();
  endtask

  task automatic test_reset_mid();
    bus.irqLines[3] = 1'b1;
    step();
    bus.irqLines[3] = 1'b0;
    step(); step(); step();
    n_checks++; if (bus.irq !== 1'b1) begin n_fail++; $display("FAIL mid_present got %0h want 1", bus.irq); end
    #2;
    reset = 1'b0;
    #1;
    n_checks++; if (bus.irq !== 1'b0 || bus.irqNumber !== 6'd0 || bus.mask !== 8'h00 || bus.pending !== 8'h00) begin
      n_fail++; $display("FAIL mid_reset got irq=%0h num=%0d mask=%0h pend=%0h want 0/0/00/00", bus.irq, bus.irqNumber, bus.mask, bus.pending);
    end
    step();
    reset = 1'b1;
    step();
  endtask

  initial begin
    test_reset();
    test_edge_latency();
    test_priority();
    test_stall_clear();
    test_withdrawal();
    test_back_to_back();
    test_spurious_exception();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
